// File: rtl/signed_subtraction_seq.sv
// Bit-serial sign-magnitude subtractor (out = a - b), one magnitude bit per cycle.
// Optional saturation on magnitude overflow: define SIGNED_SUB_SAT_EN.
module signed_subtraction_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREP   = 2'd1,
    SERIAL = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state, state_nx;

  logic [15:0] ra, rb;
  logic        op_add;
  logic        rsign;
  logic [14:0] sx, sy;
  logic [14:0] res;
  logic        cy;
  logic [3:0]  cnt;

  logic        xb, yb;
  logic        rbit, cout;
  logic [14:0] full;
  logic [14:0] mag;
  logic        ovf_nx;
  logic [15:0] out_nx;

  logic        sb;
  logic [14:0] ma, mb;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = PREP;
      end
      PREP:   state_nx = SERIAL;
      SERIAL: if (cnt == 4'd14) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One-bit full adder / full subtractor sharing the sum/difference term
  always_comb begin
    xb   = sx[0];
    yb   = sy[0];
    rbit = xb ^ yb ^ cy;
    if (op_add) cout = (xb & yb) | (cy & (xb ^ yb));
    else        cout = (~xb & yb) | (~(xb ^ yb) & cy);
    full   = {rbit, res[14:1]};
    ovf_nx = op_add & cout;
`ifdef SIGNED_SUB_SAT_EN
    mag = ovf_nx ? '1 : full;
`else
    mag = full;
`endif
    out_nx = {((mag == '0) ? 1'b0 : rsign), mag};
  end

  assign sb = ~rb[15];
  assign ma = ra[14:0];
  assign mb = rb[14:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ra     <= '0;
      rb     <= '0;
      op_add <= 1'b0;
      rsign  <= 1'b0;
      sx     <= '0;
      sy     <= '0;
      res    <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      out    <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra <= a;
            rb <= b;
          end
        end
        PREP: begin
          cy  <= 1'b0;
          cnt <= '0;
          res <= '0;
          if (ra[15] == sb) begin
            op_add <= 1'b1;
            rsign  <= ra[15];
            sx     <= ma;
            sy     <= mb;
          end else begin
            op_add <= 1'b0;
            // Larger magnitude becomes the minuend; ties keep a's sign
            if (ma >= mb) begin
              rsign <= ra[15];
              sx    <= ma;
              sy    <= mb;
            end else begin
              rsign <= sb;
              sx    <= mb;
              sy    <= ma;
            end
          end
        end
        SERIAL: begin
          sx  <= sx >> 1;
          sy  <= sy >> 1;
          cy  <= cout;
          res <= full;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd14) begin
            out <= out_nx;
            ovf <= ovf_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_subtraction_seq.sv
// Scoreboard bench for signed_subtraction_seq: integer reference model, queued expectations.
module tb_signed_subtraction_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] out;
  logic        busy;
  logic        done;
  logic        ovf;

  signed_subtraction_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .out   (out),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] out;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic stop_mon = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_cmp = n_cmp + 1;
    if (got != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: convert to signed integers, subtract, convert back
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y);
    int   vx, vy, d, m;
    logic s, o;
    logic [31:0] mv;
    vx = int'({17'b0, x[14:0]});
    vy = int'({17'b0, y[14:0]});
    if (x[15]) vx = -vx;
    if (y[15]) vy = -vy;
    d = vx - vy;
    s = (d < 0);
    m = s ? -d : d;
    o = (m > 32767);
`ifdef SIGNED_SUB_SAT_EN
    if (o) m = 32767;
`else
    m = m % 32768;
`endif
    if (m == 0) s = 1'b0;
    mv = 32'(m);
    return {o, s, mv[14:0]};
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic do_op(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] m;
    exp_t e;
    wait_idle();
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m = model(x, y);
    e.out = m[15:0];
    e.ovf = m[16];
    e.acc = cyc;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per done pulse
  initial begin
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    while (!stop_mon) begin
      @(negedge clk);
      if (prev_done) check("busy_after_done", int'(busy), 0);
      prev_done = done;
      if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("out", int'(out), int'(e.out));
          check("ovf", int'(ovf), int'(e.ovf));
          check("latency_edges", cyc - e.acc, 16);
        end
      end
    end
  end

  initial begin
    logic [15:0] ra, rb;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", int'(out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;

    do_op(16'h0005, 16'h0003);
    do_op(16'h0003, 16'h0005);
    do_op(16'h8005, 16'h0003);
    do_op(16'h8003, 16'h8005);
    do_op(16'h0005, 16'h0005);
    do_op(16'h8000, 16'h0000);
    do_op(16'h0000, 16'h8000);
    do_op(16'h7FFF, 16'h8001);
    do_op(16'hFFFF, 16'h7FFF);
    do_op(16'h7FFF, 16'h7FFF);

    // Second start while running must be ignored
    do_op(16'h0123, 16'h0023);
    repeat (4) @(posedge clk);
    #1;
    a = 16'h1111;
    b = 16'h8222;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("handshake_queue_empty", q.size(), 0);

    // Abort with reset mid-operation
    do_op(16'h0009, 16'h0001);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_busy", int'(busy), 0);
    check("abort_out", int'(out), 0);
    check("abort_ovf", int'(ovf), 0);
    repeat (25) @(negedge clk);
    do_op(16'h0009, 16'h0001);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 8 == 0) ra[14:0] = rb[14:0];
      if (i % 8 == 1) begin
        ra = {ra[15], 15'h7FFF};
        rb = {~ra[15], rb[14:0]};
      end
      do_op(ra, rb);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("final_queue_empty", q.size(), 0);
    stop_mon = 1'b1;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d reached time limit", cyc);
    $fatal(1);
  end

endmodule
